// File: rtl/inst_mem_banked.sv
// inst_mem_banked: pipelined instruction memory with a DMA burst-write port.
// Fetch: fetch_req/PC in; INST/inst_valid/inst_fault out, READ_LATENCY cycles later.
// Fetch stall: inst_mem_hazard is high while DMA owns the array.
// DMA inputs: dma_start, dma_base_addr, dma_len, dma_wdata and dma_wvalid.
// DMA outputs: dma_wready (high in BURST) and dma_done (one-cycle pulse).
// Clock and reset: cpu_clk, and cpu_rst (synchronous, active-high).
// Optional parity: define INST_MEM_PARITY_EN to store an even-parity bit per word.
// That build adds the parity_inject input.

module inst_mem_banked #(
    parameter int INST_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 32,
    parameter int NUM_WORDS       = 256,
    parameter int READ_LATENCY    = 2,
    parameter int LEN_WIDTH       = 9
) (
    input  logic                          cpu_clk,
    input  logic                          cpu_rst,
    input  logic                          fetch_req,
    input  logic [INST_ADDR_WIDTH-1:0]    PC,
    output logic [INST_WIDTH-1:0]         INST,
    output logic                          inst_valid,
    output logic                          inst_mem_hazard,
    output logic                          inst_fault,
    input  logic                          dma_start,
    input  logic [$clog2(NUM_WORDS)-1:0]  dma_base_addr,
    input  logic [LEN_WIDTH-1:0]          dma_len,
    input  logic [INST_WIDTH-1:0]         dma_wdata,
    input  logic                          dma_wvalid,
    output logic                          dma_wready,
`ifdef INST_MEM_PARITY_EN
    input  logic                          parity_inject,
`endif
    output logic                          dma_done
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_BURST,
        S_DONE
    } state_t;

    state_t state;

    logic [IDX_W-1:0]     waddr;
    logic [LEN_WIDTH-1:0] remaining;

    // Word index and range/alignment check.
    logic [INST_ADDR_WIDTH-1:0] word_full;
    logic [IDX_W-1:0]           word_idx;
    logic                       addr_fault;
    logic                       rd_fault;
    logic [INST_WIDTH-1:0]      rd_data;
    logic                       accept;
    logic                       wr_en;

    assign word_full  = PC >> 2;
    assign word_idx   = word_full[IDX_W-1:0];
    assign addr_fault = (PC[1:0] != 2'b00) ||
                        (word_full >= INST_ADDR_WIDTH'(NUM_WORDS));
    assign accept     = fetch_req && (state == S_IDLE);
    assign wr_en      = (state == S_BURST) && dma_wvalid && !cpu_rst;

    assign inst_mem_hazard = fetch_req && (state != S_IDLE);

`ifdef INST_MEM_PARITY_EN
    // MSB of each entry is the stored even-parity bit.
    logic [INST_WIDTH:0] mem [NUM_WORDS];
    logic [INST_WIDTH:0] rd_raw;

    assign rd_raw   = mem[word_idx];
    assign rd_data  = rd_raw[INST_WIDTH-1:0];
    assign rd_fault = addr_fault || (^rd_raw);

    always_ff @(posedge cpu_clk) begin
        if (wr_en) begin
            mem[waddr] <= {(^dma_wdata) ^ parity_inject, dma_wdata};
        end
    end
`else
    logic [INST_WIDTH-1:0] mem [NUM_WORDS];

    assign rd_data  = mem[word_idx];
    assign rd_fault = addr_fault;

    always_ff @(posedge cpu_clk) begin
        if (wr_en) begin
            mem[waddr] <= dma_wdata;
        end
    end
`endif

    // Read pipeline: data is sampled at acceptance, stage L-1 drives the outputs.
    logic [READ_LATENCY-1:0]                 pv;
    logic [READ_LATENCY-1:0]                 pf;
    logic [READ_LATENCY-1:0][INST_WIDTH-1:0] pd;
    logic                                    inflight;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            pv <= '0;
            pf <= '0;
            pd <= {READ_LATENCY{NOP}};
        end else begin
            pv[0] <= accept;
            pf[0] <= accept && rd_fault;
            pd[0] <= (accept && !rd_fault) ? rd_data : NOP;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pf[i] <= pf[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign INST       = pd[READ_LATENCY-1];
    assign inst_valid = pv[READ_LATENCY-1];
    assign inst_fault = pf[READ_LATENCY-1];

    // A read is still in flight while any stage before the output holds it.
    generate
        if (READ_LATENCY > 1) begin : g_inflight
            assign inflight = |pv[READ_LATENCY-2:0];
        end else begin : g_no_inflight
            assign inflight = 1'b0;
        end
    endgenerate

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state      <= S_IDLE;
            dma_wready <= 1'b0;
            dma_done   <= 1'b0;
            waddr      <= '0;
            remaining  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    dma_done <= 1'b0;
                    if (dma_start) begin
                        waddr     <= dma_base_addr;
                        remaining <= dma_len;
                        if (dma_len == '0) begin
                            state    <= S_DONE;
                            dma_done <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!inflight) begin
                        state      <= S_BURST;
                        dma_wready <= 1'b1;
                    end
                end
                S_BURST: begin
                    if (dma_wvalid) begin
                        waddr     <= waddr + IDX_W'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            state      <= S_DONE;
                            dma_wready <= 1'b0;
                            dma_done   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    dma_done <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_banked.sv
// tb_inst_mem_banked: scoreboard bench for inst_mem_banked.
// Directed fetch and DMA sequences; a negedge monitor checks every returned word.

module tb_inst_mem_banked;

    localparam int L   = 2;
    localparam int NW  = 256;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        cpu_rst;
    logic        fetch_req;
    logic [31:0] PC;
    logic [31:0] INST;
    logic        inst_valid;
    logic        inst_mem_hazard;
    logic        inst_fault;
    logic        dma_start;
    logic [7:0]  dma_base_addr;
    logic [8:0]  dma_len;
    logic [31:0] dma_wdata;
    logic        dma_wvalid;
    logic        dma_wready;
    logic        dma_done;
    logic        parity_inject;

    inst_mem_banked #(
        .INST_WIDTH(32), .INST_ADDR_WIDTH(32), .NUM_WORDS(NW),
        .READ_LATENCY(L), .LEN_WIDTH(9)
    ) dut (
        .cpu_clk(clk), .cpu_rst(cpu_rst), .fetch_req(fetch_req), .PC(PC),
        .INST(INST), .inst_valid(inst_valid),
        .inst_mem_hazard(inst_mem_hazard), .inst_fault(inst_fault),
        .dma_start(dma_start), .dma_base_addr(dma_base_addr),
        .dma_len(dma_len), .dma_wdata(dma_wdata), .dma_wvalid(dma_wvalid),
        .dma_wready(dma_wready),
`ifdef INST_MEM_PARITY_EN
        .parity_inject(parity_inject),
`endif
        .dma_done(dma_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic        fault;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [NW];
    logic [31:0] cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid response must match the oldest expectation.
    always @(negedge clk) begin
        if (!cpu_rst && inst_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got INST %h with empty queue",
                         INST);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("inst", INST, e.inst);
                check("fault", {31'b0, inst_fault}, {31'b0, e.fault});
                check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t expect_for(input logic [31:0] pc);
        exp_t e;
        e.cyc = cyc + L;
        if (pc[1:0] != 2'b00 || (pc >> 2) >= NW) begin
            e.inst  = NOP;
            e.fault = 1'b1;
        end else begin
            e.inst  = model[pc[9:2]];
            e.fault = 1'b0;
        end
        return e;
    endfunction

    task automatic fetch(input logic [31:0] pc);
        fetch_req = 1'b1;
        PC        = pc;
        sb.push_back(expect_for(pc));
        @(negedge clk);
        check("hazard_idle", {31'b0, inst_mem_hazard}, 32'd0);
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("queue_drained", sb.size(), 32'd0);
    endtask

    // Burst of len words from base; gap selects dma_wvalid per ready cycle.
    // hold keeps fetch_req high at hold_pc; rst_after>=0 resets mid-burst.
    task automatic dma_burst(input int base, input int len,
                             input logic [15:0] gap, input logic [31:0] seed,
                             input bit hold, input logic [31:0] hold_pc,
                             input int rst_after);
        int sent;
        int k;
        int done_cnt;
        bit aborted;
        sent = 0; k = 0; done_cnt = 0; aborted = 0;
        dma_start     = 1'b1;
        dma_base_addr = base[7:0];
        dma_len       = len[8:0];
        if (hold) begin
            fetch_req = 1'b1;
            PC        = hold_pc;
            sb.push_back(expect_for(hold_pc));
        end
        tick();
        dma_start = 1'b0;
        for (int c = 0; c < 700 && sent < len && !aborted; c++) begin
            dma_wvalid = 1'b0;
            if (dma_wready) begin
                if (rst_after >= 0 && sent == rst_after) begin
                    cpu_rst = 1'b1;
                    aborted = 1;
                end else begin
                    dma_wvalid = gap[k % 16];
                    k++;
                    if (dma_wvalid) begin
                        dma_wdata = seed + sent;
                        model[(base + sent) % NW] = seed + sent;
                        sent++;
                    end
                end
            end
            @(negedge clk);
            if (hold) check("hazard_busy", {31'b0, inst_mem_hazard}, 32'd1);
            done_cnt += int'(dma_done);
            tick();
        end
        dma_wvalid = 1'b0;
        cpu_rst    = 1'b0;
        if (!aborted) begin
            check("burst_words", sent, len);
            @(negedge clk);
            check("done_pulse", {31'b0, dma_done}, 32'd1);
            check("wready_done", {31'b0, dma_wready}, 32'd0);
            if (hold) check("hazard_done", {31'b0, inst_mem_hazard}, 32'd1);
            done_cnt += int'(dma_done);
            tick();
            if (hold) begin
                sb.push_back(expect_for(hold_pc));
                @(negedge clk);
                check("hazard_release", {31'b0, inst_mem_hazard}, 32'd0);
                tick();
                fetch_req = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                done_cnt += int'(dma_done);
            end
            tick();
            check("done_count", done_cnt, 32'd1);
        end else begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                done_cnt += int'(dma_done);
            end
            tick();
            check("no_done_after_rst", done_cnt, 32'd0);
            check("wready_after_rst", {31'b0, dma_wready}, 32'd0);
        end
    endtask

    initial begin
        cpu_rst = 1'b1; fetch_req = 1'b0; PC = '0; dma_start = 1'b0;
        dma_base_addr = '0; dma_len = '0; dma_wdata = '0;
        dma_wvalid = 1'b0; parity_inject = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_inst", INST, NOP);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_fault", {31'b0, inst_fault}, 32'd0);
        check("rst_hazard", {31'b0, inst_mem_hazard}, 32'd0);
        check("rst_wready", {31'b0, dma_wready}, 32'd0);
        check("rst_done", {31'b0, dma_done}, 32'd0);
        tick();
        cpu_rst = 1'b0;
        tick();

        // Fill the whole array with known words.
        dma_burst(0, 256, 16'hFFFF, 32'hA000_0000, 0, 0, -1);

        // Back-to-back fetches.
        fetch(32'h0); fetch(32'h4); fetch(32'h8);
        drain();

        // Misaligned and out-of-range.
        fetch(32'h6); fetch(32'h400);
        drain();

        // Fetch, then burst next cycle; gapped valid; hold fetch at 0x14.
        fetch(32'h14);
        dma_burst(5, 3, 16'hFFFD, 32'hC000_0000, 1, 32'h14, -1);
        drain();

        // Wrapping burst, then read the affected words plus a neighbour.
        dma_burst(254, 4, 16'hFFFF, 32'hB000_0000, 0, 0, -1);
        fetch(32'h3F8); fetch(32'h3FC); fetch(32'h0);
        fetch(32'h4); fetch(32'h8);
        drain();

        // Reset after two of four words.
        dma_burst(20, 4, 16'hFFFF, 32'hD000_0000, 0, 0, 2);
        fetch(32'h50); fetch(32'h54); fetch(32'h58); fetch(32'h5C);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/inst_mem_banked.md
Name: inst_mem_banked

Overview:
Parametrised successor to the single-cycle instruction memory. It provides a pipelined CPU fetch port with configurable read latency and a valid/stall handshake. It also provides a DMA burst-write port with its own FSM, and a real hazard output that stalls fetch while DMA owns the array. It sits between the IF stage and the DMA engine in the CPU memory subsystem.

Parameters:
INST_WIDTH, 32, instruction word width in bits
INST_ADDR_WIDTH, 32, PC / byte-address width
NUM_WORDS, 256, array depth in words; must be a power of 2
READ_LATENCY, 2, cycles from accepted fetch to inst_valid; legal range 1..4
LEN_WIDTH, 9, DMA burst-length width; must satisfy log2(NUM_WORDS)+1

Ports:
cpu_clk  in  1  sole clock, rising edge
cpu_rst  in  1  reset; one clock; reset is synchronous and active-high
fetch_req  in  1  CPU requests instruction at PC
PC  in  INST_ADDR_WIDTH  byte address of fetch
INST  out  INST_WIDTH  fetched instruction
inst_valid  out  1  INST valid this cycle
inst_mem_hazard  out  1  fetch_req not accepted this cycle; CPU must hold PC
inst_fault  out  1  qualifies inst_valid; misaligned or out-of-range fetch
dma_start  in  1  begin burst (IDLE only; ignored otherwise)
dma_base_addr  in  log2(NUM_WORDS)  word address of first write
dma_len  in  LEN_WIDTH  number of words in burst
dma_wdata  in  INST_WIDTH  write data
dma_wvalid  in  1  dma_wdata valid
dma_wready  out  1  block accepts a word (asserted in BURST)
dma_done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset: pipeline flushed.
  - Output reset values: INST=32'h00000013 (NOP), inst_valid=0, inst_fault=0, inst_mem_hazard=0, dma_wready=0, dma_done=0.
  - FSM returns to IDLE. Array contents are not cleared.
- Fetch:
  - Accepted when fetch_req=1 and the FSM is IDLE.
  - Word index = PC>>2.
  - inst_valid=1 exactly READ_LATENCY cycles after acceptance, with INST=mem[PC>>2] sampled at acceptance.
  - One acceptance per cycle; fully pipelined; throughput 1 word/cycle.
- Fault:
  - Condition: PC[1:0]!=0, or (PC>>2)>=NUM_WORDS (i.e., upper PC bits nonzero).
  - Response: the request still flows through the pipeline and returns INST=NOP with inst_fault=1.
- Hazard: inst_mem_hazard = fetch_req & (state!=IDLE); combinational.
- FSM states: IDLE, DRAIN, BURST, DONE.
  - IDLE: on dma_start, go to DRAIN. If dma_len==0, go to DONE instead.
  - DRAIN: no new fetches. Stay until all in-flight reads have returned, then go to BURST. Takes at most READ_LATENCY cycles; 0 extra cycles if the pipeline is empty.
  - BURST:
    - dma_wready=1.
    - Each cycle with dma_wvalid=1: write mem[addr] and increment addr modulo NUM_WORDS (wrap-around allowed), decrement remaining.
    - When the last word is written, go to DONE.
  - DONE: dma_done=1 for one cycle, then go to IDLE.
- Simultaneous fetch_req and dma_start in IDLE: the fetch is accepted and returns pre-burst data; the DMA then drains it.
- Reset during BURST: go to IDLE. Words already written stay written. No dma_done pulse.
- A fetch accepted in the cycle following DONE sees the newly written data (write-before-read ordering guaranteed).

Optional Feature:
INST_MEM_PARITY_EN:
- Defined:
  - Each word stores an extra even-parity bit, computed on DMA write.
  - The parity check happens on the read path. On mismatch, the response returns inst_fault=1 with INST=NOP.
  - Adds input port parity_inject (1 bit). When high during a DMA write, the stored parity bit is inverted.
- Undefined: no parity storage, no parity_inject port, and inst_fault covers only address faults.

Test Plan:
- READ_LATENCY=2; back-to-back fetches at PC=0x0, 0x4, 0x8 -> inst_valid high on cycles 2, 3, 4 with mem[0], mem[1], mem[2]; hazard stays 0.
- Fetch at PC=0x6, then PC=0x400 (NUM_WORDS=256) -> each returns INST=0x00000013 with inst_fault=1.
- Fetch accepted, dma_start (base=5, len=3) in the next cycle -> DRAIN holds until the fetch returns. BURST writes 5, 6, 7 with dma_wvalid gapped 1-0-1-1. dma_done pulses once; a fetch at PC=0x14 returns the new word.
- Burst base=254, len=4 -> words 254, 255, 0, 1 written (wrap).
- fetch_req held during BURST -> inst_mem_hazard=1 every cycle until the cycle after DONE.
- cpu_rst asserted after 2 of 4 burst words -> FSM IDLE, no dma_done, words 0 and 1 of the burst updated, the rest unchanged.
